width_conv_512_64: RTL
======================

Name: width_conv_512_64

Overview:
- AXI-Stream downsizer: accepts 512-bit beats from the LDPC core and serialises each into eight 64-bit beats toward the DMA S2MM channel.
- Return-path counterpart of width_conv_64_512.
- Lane 0 (bits 63:0) is emitted first. A 64-bit word packed by the upsizer therefore comes back in its original order.
- One 512-bit holding register; sustains one 64-bit beat per cycle, with back-to-back 512-bit input accepted on the final lane.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 512, slave (input) data width; must be C_M00_AXIS_TDATA_WIDTH * 8
- C_M00_AXIS_TDATA_WIDTH, 64, master (output) data width
- RATIO, 8, lanes per input beat (localparam, derived; counter width = clog2(RATIO) = 3)

Ports:
- aclk  in  1  sole clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- S_AXIS_TDATA  in  512  input data from LDPC
- S_AXIS_TVALID  in  1  input valid, active high
- S_AXIS_TREADY  out  1  input ready, active high
- S_AXIS_TLAST  in  1  end of packet, active high
- S_AXIS_TKEEP  in  64  byte enables (only with TKEEP_EN)
- M_AXIS_TDATA  out  64  output data to DMA
- M_AXIS_TVALID  out  1  output valid, active high
- M_AXIS_TREADY  in  1  output ready, active high
- M_AXIS_TLAST  out  1  end of packet, active high
- M_AXIS_TKEEP  out  8  byte enables (only with TKEEP_EN)

Behaviour:
- Reset: one clock and one reset. Reset is synchronous, active-high, and sampled on the rising edge of aclk. Reset clears:
  - full = 0, lane counter cnt = 0, buf_last = 0
  - M_AXIS_TVALID = 0, M_AXIS_TLAST = 0, M_AXIS_TDATA = 0, M_AXIS_TKEEP = 0
  - S_AXIS_TREADY = 0 while areset is high; it goes to 1 the first cycle after release.
- Reset mid-packet discards the buffered beat and partial lanes. No TLAST is emitted for the aborted packet.
- States:
  - EMPTY (full = 0)
  - SHIFT (full = 1, cnt < last_lane)
  - FINAL (full = 1, cnt == last_lane)
- Transitions:
  - EMPTY -> SHIFT/FINAL on an S handshake.
  - SHIFT -> cnt+1 on an M handshake.
  - FINAL -> EMPTY on an M handshake. If an S handshake happens in the same cycle, go directly to SHIFT/FINAL of the new beat with cnt = 0.
- S_AXIS_TREADY = !areset && (!full || (cnt == last_lane && M_AXIS_TREADY)). This ready is combinational from M_AXIS_TREADY. No combinational path from S_AXIS_TVALID to any output.
- S handshake latches:
  - buf <= S_AXIS_TDATA, buf_last <= S_AXIS_TLAST, cnt <= 0, full <= 1.
  - last_lane is computed at capture.
- Outputs:
  - M_AXIS_TVALID = full.
  - M_AXIS_TDATA = buf[64*cnt +: 64], muxed from registered state (no added latency).
  - M_AXIS_TLAST = buf_last && cnt == last_lane.
- Latency: first 64-bit beat is valid the cycle after the S handshake. 8 output beats per input beat. Throughput is 1 beat/cycle with M_AXIS_TREADY held high.
- Backpressure: while M_AXIS_TREADY = 0, M_AXIS_TDATA, M_AXIS_TLAST and M_AXIS_TKEEP hold stable and cnt does not advance.
- Without TKEEP_EN, last_lane is always 7. Every 512-bit beat yields exactly 8 output beats, including the TLAST beat.
- Upstream must not drop TVALID once asserted. The block does not check this.

Optional Feature:
- Macro: TKEEP_EN. When defined, S_AXIS_TKEEP and M_AXIS_TKEEP exist.
- On a TLAST beat, last_lane is the highest lane whose 8-bit TKEEP slice is non-zero. Trailing all-zero lanes are not emitted.
- A TLAST beat with TKEEP = 0 emits a single lane-0 beat with M_AXIS_TKEEP = 0x00 and TLAST = 1.
- On non-TLAST beats, TKEEP must be all ones; last_lane = 7.
- M_AXIS_TKEEP = keep_buf[8*cnt +: 8].
- Without the macro: no TKEEP ports, last_lane fixed at 7.

Test Plan:
- Reset, then one 512-bit beat with TDATA = 0x3F3E...0100 (byte n = n), TLAST = 1, M_AXIS_TREADY = 1 -> 8 beats on consecutive cycles starting 1 cycle after the handshake:
  - 0x0706050403020100, 0x0F0E0D0C0B0A0908, ..., 0x3F3E3D3C3B3A3938
  - TLAST only on the 8th beat.
- Two back-to-back input beats (second with TLAST), TVALID held high -> 16 output beats with no bubble; second S handshake coincides with the 8th output handshake.
- M_AXIS_TREADY toggling 1,0,0,1,... -> each lane held stable while ready is low, no lane lost or duplicated, S_AXIS_TREADY stays low until the final lane is accepted.
- areset asserted after 3 output beats of an 8-lane beat -> next cycle M_AXIS_TVALID = 0; a new beat afterwards starts at lane 0.
- TKEEP_EN: TLAST beat with TKEEP = 0x0000_0000_00FF_FFFF -> exactly 3 beats, M_AXIS_TKEEP = 0xFF, 0xFF, 0xFF, TLAST on the 3rd.
- TKEEP_EN: TLAST beat with TKEEP = 0 -> single beat, M_AXIS_TKEEP = 0x00, TLAST = 1.

Source files
------------

// File: rtl/width_conv_512_64_if.sv
// rtl/width_conv_512_64_if.sv - AXI-Stream bundle for the 512-to-64 downsizer
// tkeep exists only when TKEEP_EN is defined.
interface width_conv_512_64_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
`ifdef TKEEP_EN
  logic [DATA_W/8-1:0] tkeep;
`endif

  modport master (
`ifdef TKEEP_EN
    output tkeep,
`endif
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
`ifdef TKEEP_EN
    input  tkeep,
`endif
    input  tdata, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/width_conv_512_64.sv
// rtl/width_conv_512_64.sv - AXI-Stream 512-to-64 downsizer, lane 0 emitted first
// Optional macro TKEEP_EN: byte enables; trailing empty lanes of a TLAST beat are dropped.
module width_conv_512_64 #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 512,
  parameter int C_M00_AXIS_TDATA_WIDTH = 64
) (
  input  logic                aclk,
  input  logic                areset,
  width_conv_512_64_if.slave  s_axis,
  width_conv_512_64_if.master m_axis
);
  localparam int RATIO    = C_S00_AXIS_TDATA_WIDTH / C_M00_AXIS_TDATA_WIDTH;
  localparam int CNT_W    = $clog2(RATIO);
  localparam int M_KEEP_W = C_M00_AXIS_TDATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] LANE_MAX = CNT_W'(RATIO - 1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_SHIFT,
    ST_FINAL
  } state_t;

  state_t                              state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [CNT_W-1:0]                    last_lane_q, last_lane_d;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   data_q, data_d;
  logic                                last_q, last_d;
`ifdef TKEEP_EN
  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] keep_q, keep_d;
`endif
  logic [CNT_W-1:0]                    cnt_inc;
  logic [CNT_W-1:0]                    cap_last_lane;
  logic                                s_ready, s_hs, m_hs;

  // Final lane of the beat being captured: highest non-empty lane of a TLAST beat.
  always_comb begin
    cap_last_lane = LANE_MAX;
`ifdef TKEEP_EN
    if (s_axis.tlast) begin
      cap_last_lane = '0;
      for (int i = 0; i < RATIO; i++) begin
        if (s_axis.tkeep[8*i +: 8] != 8'h00) begin
          cap_last_lane = CNT_W'(i);
        end
      end
    end
`endif
  end

  always_comb begin
    s_ready     = !areset && (state_q == ST_EMPTY ||
                              (state_q == ST_FINAL && m_axis.tready));
    s_hs        = s_axis.tvalid && s_ready;
    m_hs        = (state_q != ST_EMPTY) && m_axis.tready;
    cnt_inc     = cnt_q + CNT_W'(1);
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_lane_d = last_lane_q;
    data_d      = data_q;
    last_d      = last_q;
`ifdef TKEEP_EN
    keep_d      = keep_q;
`endif
    // Capture can only coincide with the final-lane M handshake, so it takes priority.
    if (s_hs) begin
      data_d      = s_axis.tdata;
      last_d      = s_axis.tlast;
`ifdef TKEEP_EN
      keep_d      = s_axis.tkeep;
`endif
      cnt_d       = '0;
      last_lane_d = cap_last_lane;
      state_d     = (cap_last_lane == '0) ? ST_FINAL : ST_SHIFT;
    end else if (m_hs) begin
      if (state_q == ST_FINAL) begin
        state_d = ST_EMPTY;
      end else begin
        cnt_d = cnt_inc;
        if (cnt_inc == last_lane_q) begin
          state_d = ST_FINAL;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_EMPTY;
      cnt_q       <= '0;
      last_lane_q <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
`ifdef TKEEP_EN
      keep_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_lane_q <= last_lane_d;
      data_q      <= data_d;
      last_q      <= last_d;
`ifdef TKEEP_EN
      keep_q      <= keep_d;
`endif
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = (state_q != ST_EMPTY);
  assign m_axis.tdata  = data_q[C_M00_AXIS_TDATA_WIDTH*int'(cnt_q) +: C_M00_AXIS_TDATA_WIDTH];
  assign m_axis.tlast  = last_q && (state_q == ST_FINAL);
`ifdef TKEEP_EN
  assign m_axis.tkeep  = keep_q[M_KEEP_W*int'(cnt_q) +: M_KEEP_W];
`endif
endmodule
